// File: rtl/pinwheel_hart_sched.sv
// Barrel-thread hart scheduler: per-hart PC table plus a round-robin issuer that skips sleeping and in-flight harts.
// Optional PINWHEEL_SCHED_BYPASS_EN lets harts written back or woken this edge issue in the same edge.

module pinwheel_hart_slot #(
  parameter int                 PC_BITS = 24,
  parameter logic [PC_BITS-1:0] RST_PC  = '0,
  parameter bit                 RST_ACT = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wb_hit,
  input  logic               wb_sleep,
  input  logic [PC_BITS-1:0] wb_pc,
  input  logic               wake_hit,
  input  logic [PC_BITS-1:0] wake_pc,
  input  logic               issue_hit,
  output logic               active,
  output logic               busy,
  output logic               run_nxt,
  output logic [PC_BITS-1:0] pc_nxt
);
  localparam logic [PC_BITS-1:0] ALIGN = ~PC_BITS'(3);

  logic [PC_BITS-1:0] pc;
  logic               act_nxt;

  // Wake is applied after writeback, so a same-edge sleep+wake leaves the hart awake.
  always_comb begin
    pc_nxt  = pc;
    act_nxt = active;
    if (wb_hit) begin
      pc_nxt = wb_pc & ALIGN;
      if (wb_sleep) act_nxt = 1'b0;
    end
    if (wake_hit) begin
      pc_nxt  = wake_pc & ALIGN;
      act_nxt = 1'b1;
    end
    run_nxt = act_nxt & ~(busy & ~wb_hit);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= RST_PC;
      active <= RST_ACT;
      busy   <= 1'b0;
    end else begin
      pc     <= pc_nxt;
      active <= act_nxt;
      busy   <= (busy & ~wb_hit) | issue_hit;
    end
  end
endmodule

module pinwheel_hart_sched #(
  parameter int                 NUM_HARTS = 8,
  parameter int                 HART_BITS = 3,
  parameter int                 PC_BITS   = 24,
  parameter logic [PC_BITS-1:0] RESET_PC  = 24'h400000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 wb_valid,
  input  logic [HART_BITS-1:0] wb_hart,
  input  logic [PC_BITS-1:0]   wb_pc,
  input  logic                 wb_sleep,
  input  logic                 wake_valid,
  input  logic [HART_BITS-1:0] wake_hart,
  input  logic [PC_BITS-1:0]   wake_pc,
  output logic                 issue_valid,
  output logic [HART_BITS-1:0] issue_hart,
  output logic [31:0]          issue_hpc,
  output logic [NUM_HARTS-1:0] active_mask,
  output logic [NUM_HARTS-1:0] busy_mask,
  output logic                 err,
  output logic [31:0]          ticks
);
  logic [NUM_HARTS-1:0]              wb_hit, wake_hit, issue_hit, run_nxt, elig, act_after_wb, sh;
  logic [NUM_HARTS-1:0][PC_BITS-1:0] pc_nxt;
  logic [HART_BITS-1:0]              last, pick;
  logic                              wb_ok, wake_ok, err_set, found, do_issue;
  int                                idx;

  for (genvar g = 0; g < NUM_HARTS; g++) begin : g_slot
    pinwheel_hart_slot #(
      .PC_BITS (PC_BITS),
      .RST_PC  ((g == 0) ? RESET_PC : '0),
      .RST_ACT (g == 0)
    ) u_slot (
      .clock     (clock),
      .reset_n   (reset_n),
      .wb_hit    (wb_hit[g]),
      .wb_sleep  (wb_sleep),
      .wb_pc     (wb_pc),
      .wake_hit  (wake_hit[g]),
      .wake_pc   (wake_pc),
      .issue_hit (issue_hit[g]),
      .active    (active_mask[g]),
      .busy      (busy_mask[g]),
      .run_nxt   (run_nxt[g]),
      .pc_nxt    (pc_nxt[g])
    );
  end

  always_comb begin
    wb_ok        = wb_valid && (int'(wb_hart) < NUM_HARTS) && busy_mask[wb_hart];
    wb_hit       = wb_ok ? (NUM_HARTS'(1) << wb_hart) : '0;
    act_after_wb = active_mask & ~(wb_hit & {NUM_HARTS{wb_sleep}});
    wake_ok      = wake_valid && (int'(wake_hart) < NUM_HARTS) && !act_after_wb[wake_hart];
    wake_hit     = wake_ok ? (NUM_HARTS'(1) << wake_hart) : '0;
    err_set      = (wb_valid && !wb_ok) || (wake_valid && !wake_ok);
  end

`ifdef PINWHEEL_SCHED_BYPASS_EN
  assign elig = run_nxt;
`else
  assign elig = active_mask & ~busy_mask;
`endif

  // Round-robin search starting just past the last issued hart.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    sh    = '0;
    for (int i = 1; i <= NUM_HARTS; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_HARTS) idx = idx - NUM_HARTS;
      sh = elig >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        pick  = HART_BITS'(idx);
      end
    end
    do_issue  = found && !stall;
    issue_hit = do_issue ? (NUM_HARTS'(1) << pick) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last        <= HART_BITS'(NUM_HARTS - 1);
      issue_valid <= 1'b0;
      issue_hart  <= '0;
      issue_hpc   <= '0;
      err         <= 1'b0;
      ticks       <= '0;
    end else begin
      issue_valid <= do_issue;
      issue_hart  <= do_issue ? pick : '0;
      issue_hpc   <= do_issue ? ((32'(pick) << PC_BITS) | 32'(pc_nxt[pick])) : '0;
      if (do_issue) last <= pick;
      err         <= err | err_set;
      ticks       <= ticks + 32'd1;
    end
  end
endmodule
